trace_buf_ctrl: RTL and testbench
=================================

Name: trace_buf_ctrl

Overview:
Capture controller that sits directly upstream of the 256x32 dual-port trace RAM (RAM_2_PORT). It drives that RAM: port A writes streaming LLRF samples as a circular pre/post-trigger buffer, and port B reads the frozen buffer back for the host. Host reads use logical indices, where 0 is the oldest sample, and this block maps them to physical RAM addresses.

Parameters:
ADDR_W, 8, RAM address width; DEPTH = 2**ADDR_W
DATA_W, 32, sample and RAM data width
RD_LAT, 2, port-B read latency of the attached RAM in clocks (address to q_b)

Ports:
clock  in  1  single system clock
reset  in  1  asynchronous, active-high reset
smp_data  in  DATA_W  sample word
smp_valid  in  1  sample strobe, one sample per cycle max
arm  in  1  single-cycle pulse; starts or restarts a capture
trig  in  1  trigger; rising edge detected internally
post_len  in  ADDR_W  samples to store from the trigger sample on; latched at the trigger
rd_req  in  1  host read strobe
rd_addr  in  ADDR_W  logical read index, 0 = oldest
rd_data  out  DATA_W  read data (ram_q_b passthrough)
rd_valid  out  1  marks rd_data valid
state  out  2  0 IDLE, 1 RUN, 2 POST, 3 DONE
done  out  1  high in DONE
fill  out  ADDR_W+1  valid samples held, saturates at DEPTH
trig_ptr  out  ADDR_W  physical address of the trigger sample
ram_data_a  out  DATA_W  to RAM data_a
ram_address_a  out  ADDR_W  to RAM address_a
ram_wren_a  out  1  to RAM wren_a
ram_data_b  out  DATA_W  to RAM data_b; tied 0
ram_address_b  out  ADDR_W  to RAM address_b
ram_wren_b  out  1  to RAM wren_b; tied 0
ram_q_b  in  DATA_W  from RAM q_b

Behaviour:
- Reset (async, active-high): every register clears to 0. Outputs: state=IDLE, done=0, fill=0, trig_ptr=0, rd_valid=0, ram_wren_a=0, ram_address_a/b=0. Reset mid-capture aborts to IDLE; RAM contents are untouched.
- Write path: registered.
  - ram_wren_a = smp_valid while in RUN or POST (one-cycle registered delay).
  - ram_address_a = wr_ptr; ram_data_a = smp_data.
  - wr_ptr increments mod DEPTH per write; fill increments per write and saturates at DEPTH.
- Trigger edge: trig_re = trig & ~trig_q, with trig_q registered.
- IDLE -> RUN on arm: clears wr_ptr, fill, done and post_cnt.
- arm in any state restarts exactly as above. arm wins over a same-cycle trig_re.
- RUN -> POST on trig_re, provided post_len != 0:
  - trig_ptr <= wr_ptr; post_len is latched.
  - A same-cycle valid sample is the trigger sample and counts as post sample 1.
- RUN -> DONE on trig_re with post_len == 0: trig_ptr <= wr_ptr; the trigger-cycle sample is not written.
- POST -> DONE when post_cnt reaches the latched post_len. This includes the same-cycle case where post_len == 1 and smp_valid is high at the trigger. No write occurs after DONE.
- trig_re in POST or DONE is ignored. trig_re in IDLE is ignored.
- Read path, valid only in DONE:
  - ram_address_b = base + rd_addr mod DEPTH, where base = wr_ptr if fill == DEPTH, else 0.
  - rd_valid pulses RD_LAT cycles after rd_req through a shift register, so back-to-back reads pipeline.
  - rd_req outside DONE is ignored and produces no rd_valid.
  - rd_addr >= fill returns stale RAM data with rd_valid still asserted; the host must range-check against fill.
- Shift-register entries already in flight when arm or reset arrives: reset clears them; arm does not.

Optional Feature:
TRACE_PRETRIG_GUARD_EN.
- Defined: in RUN, trig_re is ignored until fill >= DEPTH - post_len, which guarantees a full pre-trigger history.
- Undefined: trig_re is accepted on any RUN cycle.

Test Plan:
1. Reset held, then released with no stimulus -> state=0, done=0, fill=0, ram_wren_a=0, rd_valid=0; rd_req in IDLE yields no rd_valid.
2. arm; continuous samples data=i; trig rising together with sample 290; post_len=20 -> samples 290..309 written, DONE, trig_ptr=34, fill=256. Reads:
   - rd_addr 0 -> ram_address_b=54, rd_data=54, rd_valid exactly 2 cycles later.
   - rd_addr 255 -> rd_data=309.
   - rd_addr 236 -> rd_data=290.
3. arm; trig with sample 10; post_len=5 -> fill=15, trig_ptr=10, rd_addr 0 -> data 0, rd_addr 14 -> data 14.
4. arm; 3 samples; trig with post_len=0 -> DONE next cycle, fill=3, trig_ptr=3, trigger-cycle sample not written (wren_a=0).
5. arm; trig; during POST pulse arm -> state=RUN, fill=0, wr_ptr=0. Repeat with reset asserted mid-POST -> IDLE at once, all outputs 0.
6. Guard feature: post_len=56, trig at sample 100 -> defined: trigger ignored, state stays RUN; undefined: state=POST, trig_ptr=100.

Source files
------------

// File: rtl/trace_buf_ctrl.sv
// trace_buf_ctrl: capture controller for a 256x32 dual-port trace RAM.
// Port A streams samples into a circular pre/post-trigger buffer; port B
// reads the frozen buffer back using logical indices (0 = oldest sample).
// Optional macro TRACE_PRETRIG_GUARD_EN: when defined, a trigger in RUN is
// only accepted once fill >= DEPTH - post_len, so the pre-trigger history
// is always complete. When undefined, a trigger is accepted on any RUN cycle.
module trace_buf_ctrl #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] smp_data,
    input  logic              smp_valid,
    input  logic              arm,
    input  logic              trig,
    input  logic [ADDR_W-1:0] post_len,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [1:0]        state,
    output logic              done,
    output logic [ADDR_W:0]   fill,
    output logic [ADDR_W-1:0] trig_ptr,
    output logic [DATA_W-1:0] ram_data_a,
    output logic [ADDR_W-1:0] ram_address_a,
    output logic              ram_wren_a,
    output logic [DATA_W-1:0] ram_data_b,
    output logic [ADDR_W-1:0] ram_address_b,
    output logic              ram_wren_b,
    input  logic [DATA_W-1:0] ram_q_b
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0]   DEPTH_V  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   FILL_ONE = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_POST = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic                trig_q;
    logic                trig_re;
    logic                trig_ok;
    logic [ADDR_W-1:0]   wr_ptr;
    logic [ADDR_W-1:0]   post_len_q;
    logic [ADDR_W-1:0]   post_cnt_q;
    logic [ADDR_W:0]     post_cnt_nx;
    logic                wr_en;
    logic                trig_take;
    logic                restart;
    logic                rd_accept;
    logic [ADDR_W-1:0]   base;
    logic [RD_LAT-1:0]   rd_pipe;

    assign trig_re     = trig & ~trig_q;
    assign post_cnt_nx = {1'b0, post_cnt_q} + FILL_ONE;

`ifdef TRACE_PRETRIG_GUARD_EN
    logic [ADDR_W:0] guard_thr;
    assign guard_thr = DEPTH_V - {1'b0, post_len};
    assign trig_ok   = (fill >= guard_thr);
`else
    assign trig_ok   = 1'b1;
`endif

    assign state      = state_q;
    assign done       = (state_q == S_DONE);
    assign ram_data_b = '0;
    assign ram_wren_b = 1'b0;

    // Once the buffer has wrapped, the oldest sample sits at the write pointer.
    assign base          = (fill == DEPTH_V) ? wr_ptr : '0;
    assign ram_address_b = (state_q == S_DONE) ? (base + rd_addr) : '0;
    assign rd_accept     = rd_req && (state_q == S_DONE);
    assign rd_data       = ram_q_b;
    assign rd_valid      = rd_pipe[RD_LAT-1];

    // State register for the capture FSM.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode plus the write/trigger strobes that drive the datapath.
    always_comb begin
        state_d   = state_q;
        wr_en     = 1'b0;
        trig_take = 1'b0;
        restart   = 1'b0;
        if (arm) begin
            state_d = S_RUN;
            restart = 1'b1;
        end else begin
            case (state_q)
                S_RUN: begin
                    if (trig_re && trig_ok) begin
                        trig_take = 1'b1;
                        if (post_len == '0) begin
                            state_d = S_DONE;
                        end else begin
                            wr_en = smp_valid;
                            if (smp_valid && (post_len == PTR_ONE)) begin
                                state_d = S_DONE;
                            end else begin
                                state_d = S_POST;
                            end
                        end
                    end else begin
                        wr_en = smp_valid;
                    end
                end
                S_POST: begin
                    if (smp_valid) begin
                        wr_en = 1'b1;
                        if (post_cnt_nx == {1'b0, post_len_q}) begin
                            state_d = S_DONE;
                        end
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    // Write port, pointers, fill level and trigger bookkeeping.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            trig_q        <= 1'b0;
            wr_ptr        <= '0;
            fill          <= '0;
            trig_ptr      <= '0;
            post_len_q    <= '0;
            post_cnt_q    <= '0;
            ram_wren_a    <= 1'b0;
            ram_address_a <= '0;
            ram_data_a    <= '0;
        end else begin
            trig_q <= trig;
            if (restart) begin
                wr_ptr     <= '0;
                fill       <= '0;
                post_cnt_q <= '0;
                ram_wren_a <= 1'b0;
            end else begin
                ram_wren_a <= wr_en;
                if (wr_en) begin
                    ram_address_a <= wr_ptr;
                    ram_data_a    <= smp_data;
                    wr_ptr        <= wr_ptr + PTR_ONE;
                    if (fill != DEPTH_V) begin
                        fill <= fill + FILL_ONE;
                    end
                end
                if (trig_take) begin
                    trig_ptr   <= wr_ptr;
                    post_len_q <= post_len;
                    post_cnt_q <= {{(ADDR_W-1){1'b0}}, smp_valid};
                end else if ((state_q == S_POST) && wr_en) begin
                    post_cnt_q <= post_cnt_nx[ADDR_W-1:0];
                end
            end
        end
    end

    // Read-valid delay line matching the RAM port-B latency; arm does not flush it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_pipe <= '0;
        end else begin
            rd_pipe[0] <= rd_accept;
            for (int i = 1; i < RD_LAT; i++) begin
                rd_pipe[i] <= rd_pipe[i-1];
            end
        end
    end

endmodule

// File: tb/tb_trace_buf_ctrl.sv
// tb_trace_buf_ctrl: directed bench for trace_buf_ctrl with a behavioural
// 2-cycle dual-port RAM and a scoreboard of expected read results.
module tb_trace_buf_ctrl;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;
    localparam int RD_LAT = 2;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [DATA_W-1:0] smp_data;
    logic              smp_valid;
    logic              arm;
    logic              trig;
    logic [ADDR_W-1:0] post_len;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic [1:0]        state;
    logic              done;
    logic [ADDR_W:0]   fill;
    logic [ADDR_W-1:0] trig_ptr;
    logic [DATA_W-1:0] ram_data_a;
    logic [ADDR_W-1:0] ram_address_a;
    logic              ram_wren_a;
    logic [DATA_W-1:0] ram_data_b;
    logic [ADDR_W-1:0] ram_address_b;
    logic              ram_wren_b;
    logic [DATA_W-1:0] ram_q_b;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    logic [DATA_W-1:0] mem [0:255];
    logic [ADDR_W-1:0] addr_b_q;
    logic [DATA_W-1:0] q_b_q;

    trace_buf_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
        .clock(clock), .reset(reset), .smp_data(smp_data), .smp_valid(smp_valid),
        .arm(arm), .trig(trig), .post_len(post_len), .rd_req(rd_req), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_valid(rd_valid), .state(state), .done(done), .fill(fill),
        .trig_ptr(trig_ptr), .ram_data_a(ram_data_a), .ram_address_a(ram_address_a),
        .ram_wren_a(ram_wren_a), .ram_data_b(ram_data_b), .ram_address_b(ram_address_b),
        .ram_wren_b(ram_wren_b), .ram_q_b(ram_q_b)
    );

    // Free-running clock.
    always #5 clock = ~clock;

    // Edge counter used to time read latency.
    always @(posedge clock) cyc <= cyc + 1;

    // Behavioural RAM: registered address and registered output on port B.
    always @(posedge clock) begin
        if (ram_wren_a) mem[ram_address_a] <= ram_data_a;
        addr_b_q <= ram_address_b;
        q_b_q    <= mem[addr_b_q];
    end
    assign ram_q_b = q_b_q;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] d, input logic t);
        smp_valid = v;
        smp_data  = d;
        trig      = t;
        step();
    endtask

    task automatic doArm();
        arm       = 1'b1;
        smp_valid = 1'b0;
        trig      = 1'b0;
        step();
        arm = 1'b0;
    endtask

    task automatic doRead(input logic [7:0] a, input logic [7:0] exp_addr, input logic [31:0] exp_data);
        exp_t e;
        rd_req  = 1'b1;
        rd_addr = a;
        #1;
        checkOutput("ram_address_b", {24'b0, ram_address_b}, {24'b0, exp_addr});
        e.data = exp_data;
        e.due  = cyc + RD_LAT;
        sb.push_back(e);
        @(posedge clock);
        #1;
    endtask

    task automatic drain();
        rd_req = 1'b0;
        for (int i = 0; i < 8 && sb.size() != 0; i++) step();
        checkOutput("sb_drain", sb.size(), 0);
    endtask

    // Scoreboard monitor: every rd_valid must match the oldest pending read.
    always @(negedge clock) begin
        exp_t e;
        if (!reset && rd_valid) begin
            if (sb.size() == 0) begin
                checkOutput("rd_spurious", {31'b0, rd_valid}, 0);
            end else begin
                e = sb.pop_front();
                checkOutput("rd_data", rd_data, e.data);
                checkOutput("rd_latency", cyc, e.due);
            end
        end
    end

    // Watchdog so the run can never hang.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog");
    end

    // Directed stimulus sequence.
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        smp_data = '0; smp_valid = 1'b0; arm = 1'b0; trig = 1'b0;
        post_len = '0; rd_req = 1'b0; rd_addr = '0;
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        // Reset state and read attempts in IDLE
        step();
        checkOutput("rst_state", {30'b0, state}, 0);
        checkOutput("rst_done", {31'b0, done}, 0);
        checkOutput("rst_fill", {23'b0, fill}, 0);
        checkOutput("rst_wren_a", {31'b0, ram_wren_a}, 0);
        checkOutput("rst_rd_valid", {31'b0, rd_valid}, 0);
        checkOutput("rst_trig_ptr", {24'b0, trig_ptr}, 0);
        rd_req = 1'b1; rd_addr = 8'd5;
        step();
        rd_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput("idle_rd_valid", {31'b0, rd_valid}, 0);
        end

        // Wrapped capture: trigger at sample 290, 20 post samples
        post_len = 8'd20;
        doArm();
        checkOutput("arm_state", {30'b0, state}, 1);
        for (int i = 0; i <= 290; i++) applyStimulus(1'b1, i, i >= 290);
        checkOutput("t2_post_state", {30'b0, state}, 2);
        checkOutput("t2_trig_ptr", {24'b0, trig_ptr}, 34);
        for (int i = 291; i < 310; i++) applyStimulus(1'b1, i, 1'b1);
        checkOutput("t2_done_state", {30'b0, state}, 3);
        checkOutput("t2_done", {31'b0, done}, 1);
        checkOutput("t2_fill", {23'b0, fill}, 256);
        applyStimulus(1'b1, 999, 1'b1);
        checkOutput("t2_no_write_after_done", {31'b0, ram_wren_a}, 0);
        smp_valid = 1'b0; trig = 1'b0;
        doRead(8'd0, 8'd54, 54);
        doRead(8'd255, 8'd53, 309);
        doRead(8'd236, 8'd34, 290);
        drain();

        // Short capture without wrap
        post_len = 8'd5;
        doArm();
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, i, 1'b0);
        applyStimulus(1'b1, 10, 1'b1);
        checkOutput("t3_post_state", {30'b0, state}, 2);
        checkOutput("t3_trig_ptr", {24'b0, trig_ptr}, 10);
        for (int i = 11; i < 15; i++) applyStimulus(1'b1, i, 1'b1);
        checkOutput("t3_done_state", {30'b0, state}, 3);
        checkOutput("t3_fill", {23'b0, fill}, 15);
        smp_valid = 1'b0; trig = 1'b0;
        doRead(8'd0, 8'd0, 0);
        doRead(8'd14, 8'd14, 14);
        drain();

        // Zero post length: trigger sample dropped
        post_len = 8'd0;
        doArm();
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, i, 1'b0);
        applyStimulus(1'b1, 77, 1'b1);
        checkOutput("t4_state", {30'b0, state}, 3);
        checkOutput("t4_trig_ptr", {24'b0, trig_ptr}, 3);
        checkOutput("t4_wren_a", {31'b0, ram_wren_a}, 0);
        checkOutput("t4_fill", {23'b0, fill}, 3);
        smp_valid = 1'b0; trig = 1'b0;

        // Re-arm during POST, then reset during POST
        post_len = 8'd20;
        doArm();
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, i, 1'b0);
        applyStimulus(1'b1, 5, 1'b1);
        checkOutput("t5_post_state", {30'b0, state}, 2);
        applyStimulus(1'b1, 6, 1'b1);
        arm = 1'b1; smp_valid = 1'b0;
        step();
        arm = 1'b0;
        checkOutput("t5_rearm_state", {30'b0, state}, 1);
        checkOutput("t5_rearm_fill", {23'b0, fill}, 0);
        applyStimulus(1'b1, 50, 1'b0);
        checkOutput("t5_wr_ptr_zero", {24'b0, ram_address_a}, 0);
        checkOutput("t5_wren_a", {31'b0, ram_wren_a}, 1);
        applyStimulus(1'b1, 51, 1'b0);
        applyStimulus(1'b1, 52, 1'b1);
        checkOutput("t5_post_again", {30'b0, state}, 2);
        applyStimulus(1'b1, 53, 1'b1);
        #2 reset = 1'b1;
        #1;
        checkOutput("t5_rst_state", {30'b0, state}, 0);
        checkOutput("t5_rst_done", {31'b0, done}, 0);
        checkOutput("t5_rst_fill", {23'b0, fill}, 0);
        checkOutput("t5_rst_trig_ptr", {24'b0, trig_ptr}, 0);
        checkOutput("t5_rst_wren_a", {31'b0, ram_wren_a}, 0);
        checkOutput("t5_rst_addr_a", {24'b0, ram_address_a}, 0);
        checkOutput("t5_rst_addr_b", {24'b0, ram_address_b}, 0);
        checkOutput("t5_rst_rd_valid", {31'b0, rd_valid}, 0);
        smp_valid = 1'b0; trig = 1'b0;
        @(posedge clock);
        #1 reset = 1'b0;

        // Pre-trigger guard
        post_len = 8'd56;
        doArm();
        for (int i = 0; i < 100; i++) applyStimulus(1'b1, i, 1'b0);
        applyStimulus(1'b1, 100, 1'b1);
`ifdef TRACE_PRETRIG_GUARD_EN
        checkOutput("t6_guard_state", {30'b0, state}, 1);
`else
        checkOutput("t6_state", {30'b0, state}, 2);
        checkOutput("t6_trig_ptr", {24'b0, trig_ptr}, 100);
`endif
        smp_valid = 1'b0; trig = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
